// File: rtl/dmem_responder.sv
// Word-addressed data memory with byte-strobed stores, a programmable wait-state delay
// and valid/ready request and response channels.
module dmem_responder #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned WAIT  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW        = (WAIT > 1) ? $clog2(WAIT) : 1;
  localparam int unsigned WAIT_LOAD = (WAIT > 0) ? WAIT - 1 : 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAITST = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [CW-1:0]   cnt, cnt_next;

  logic            cap_we;
  logic [31:0]     cap_addr;
  logic [31:0]     cap_wdata;
  logic [3:0]      cap_be;

  logic            acc_we_c;
  logic [31:0]     acc_addr_c;
  logic [31:0]     acc_wdata_c;
  logic [3:0]      acc_be_c;
  logic            acc_err_c;
  logic [AW-1:0]   acc_idx_c;
  logic            commit_c;
  logic            mem_wr_c;

  logic [31:0]     mem [DEPTH];

  // Next-state and wait counter
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          if (WAIT == 0) begin
            state_next = RESP;
          end else begin
            state_next = WAITST;
            cnt_next   = CW'(WAIT_LOAD);
          end
        end
      end
      WAITST: begin
        if (cnt == '0) begin
          state_next = RESP;
        end else begin
          cnt_next = cnt - CW'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    // Reset wins so that an abandoned transaction can never commit
    if (rst) begin
      state_next = IDLE;
      cnt_next   = '0;
    end
  end

  // With WAIT=0 the access commits on the accepting edge, so use the live request
  always_comb begin
    acc_we_c    = cap_we;
    acc_addr_c  = cap_addr;
    acc_wdata_c = cap_wdata;
    acc_be_c    = cap_be;
    if (state == IDLE) begin
      acc_we_c    = req_we;
      acc_addr_c  = req_addr;
      acc_wdata_c = req_wdata;
      acc_be_c    = req_be;
    end
    acc_err_c = (acc_addr_c[1:0] != 2'b00) ||
                ({2'b00, acc_addr_c[31:2]} >= 32'(DEPTH));
    acc_idx_c = acc_addr_c[AW+1:2];
    commit_c  = (state_next == RESP) && (state != RESP);
    mem_wr_c  = commit_c && !acc_err_c && acc_we_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_we    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_be    <= '0;
    end else if (state == IDLE && req_valid) begin
      cap_we    <= req_we;
      cap_addr  <= req_addr;
      cap_wdata <= req_wdata;
      cap_be    <= req_be;
    end
  end

  // Memory array is deliberately not reset
  always_ff @(posedge clk) begin
    if (mem_wr_c) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_be_c[i]) begin
          mem[acc_idx_c][8*i +: 8] <= acc_wdata_c[8*i +: 8];
        end
      end
    end
  end

  // Registered handshake and response outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      req_ready <= (state_next == IDLE);
      rsp_valid <= (state_next == RESP);
      if (commit_c) begin
        rsp_err   <= acc_err_c;
        rsp_rdata <= (!acc_err_c && !acc_we_c) ? mem[acc_idx_c] : 32'h0;
      end else if (state == RESP && rsp_ready) begin
        rsp_err   <= 1'b0;
        rsp_rdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: two instances (WAIT=2 and WAIT=0) checked
// against directed vectors, corner-case sequences and a word-array reference model.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_ready;
  logic [1:0]  req_ready_w;
  logic [1:0]  rsp_valid_w;
  logic [1:0]  rsp_err_w;
  logic [31:0] rsp_rdata_w [2];

  int errors = 0;
  int checks = 0;

  logic [31:0] mdl [2][DEPTH];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(DEPTH), .WAIT(2)) u_w2 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready_w[0]),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid_w[0]), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata_w[0]), .rsp_err(rsp_err_w[0])
  );

  dmem_responder #(.DEPTH(DEPTH), .WAIT(0)) u_w0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready_w[1]),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid_w[1]), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata_w[1]), .rsp_err(rsp_err_w[1])
  );

  function automatic int wait_of(input int sel);
    return (sel == 0) ? 2 : 0;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // {req_ready, rsp_valid, rsp_err, rsp_rdata} of one instance
  function automatic logic [63:0] outs(input int sel);
    return {29'd0, req_ready_w[sel], rsp_valid_w[sel], rsp_err_w[sel], rsp_rdata_w[sel]};
  endfunction

  // Reference: fault rules, byte-merge on store, full word on load
  task automatic model(input int sel, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be,
                       output logic [31:0] exp_rdata, output logic exp_err);
    int unsigned word;
    word      = addr / 4;
    exp_err   = (addr % 4 != 0) || (word >= DEPTH);
    exp_rdata = 32'h0;
    if (!exp_err) begin
      if (we) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) mdl[sel][word][8*b +: 8] = wdata[8*b +: 8];
      end else begin
        exp_rdata = mdl[sel][word];
      end
    end
  endtask

  // One transaction; holds the response for 'hold' cycles while presenting a junk request
  task automatic txn(input int sel, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be, input int hold,
                     output logic [31:0] rdata, output logic err);
    int lat;
    logic [63:0] held;
    @(negedge clk);
    chk("req_ready before request", 64'(req_ready_w[sel]), 64'd1);
    req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    req_valid[sel] = 1'b1;
    rsp_ready = 1'b0;
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      req_valid[sel] = 1'b0;
    end while (!rsp_valid_w[sel] && lat < 50);
    if (!rsp_valid_w[sel]) begin
      chk("rsp_valid timeout", 64'(rsp_valid_w[sel]), 64'd1);
      rdata = 32'h0; err = 1'b0;
      return;
    end
    chk("latency", 64'(lat), 64'(wait_of(sel) + 1));
    held = outs(sel);
    chk("req_ready low in RESP", 64'(req_ready_w[sel]), 64'd0);
    for (int h = 0; h < hold; h++) begin
      req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h0; req_be = 4'hF;
      req_valid[sel] = 1'b1;
      @(negedge clk);
      chk("backpressure hold", outs(sel), held);
    end
    rdata = rsp_rdata_w[sel];
    err   = rsp_err_w[sel];
    req_valid[sel] = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("after handshake", outs(sel), {29'd0, 1'b1, 1'b0, 1'b0, 32'h0});
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          hold;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [15];

  initial begin
    logic [31:0] rd, erd;
    logic        er, eer;
    int          lat;

    rst = 1'b1; req_valid = '0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_be = '0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      for (int s = 0; s < 2; s++)
        chk("reset idle", outs(s), {29'd0, 1'b1, 1'b0, 1'b0, 32'h0});
    end

    // Known contents for the words the tests touch
    for (int s = 0; s < 2; s++) begin
      for (int w = 0; w < 17; w++) begin
        int unsigned idx;
        idx = (w == 16) ? DEPTH - 1 : w;
        model(s, 1'b1, 32'(idx * 4), 32'h0, 4'hF, erd, eer);
        txn(s, 1'b1, 32'(idx * 4), 32'h0, 4'hF, 0, rd, er);
      end
    end

    vecs[0]  = '{1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 32'h0, 1'b0};
    vecs[1]  = '{1'b0, 32'h10, 32'h0, 4'h0, 0, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h20, 32'h11223344, 4'hF, 0, 32'h0, 1'b0};
    vecs[3]  = '{1'b1, 32'h20, 32'hAABBCCDD, 4'h5, 0, 32'h0, 1'b0};
    vecs[4]  = '{1'b0, 32'h20, 32'h0, 4'hF, 0, 32'h11BB33DD, 1'b0};
    vecs[5]  = '{1'b0, 32'h22, 32'h0, 4'hF, 0, 32'h0, 1'b1};
    vecs[6]  = '{1'b1, 32'h00, 32'hCAFEF00D, 4'hF, 0, 32'h0, 1'b0};
    vecs[7]  = '{1'b1, 32'(4 * DEPTH), 32'h12345678, 4'hF, 0, 32'h0, 1'b1};
    vecs[8]  = '{1'b0, 32'h00, 32'h0, 4'h0, 0, 32'hCAFEF00D, 1'b0};
    vecs[9]  = '{1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 0, 32'h0, 1'b0};
    vecs[10] = '{1'b0, 32'h20, 32'h0, 4'h0, 0, 32'h11BB33DD, 1'b0};
    vecs[11] = '{1'b0, 32'h10, 32'h0, 4'h0, 4, 32'hDEADBEEF, 1'b0};
    vecs[12] = '{1'b0, 32'h10, 32'h0, 4'h0, 0, 32'hDEADBEEF, 1'b0};
    vecs[13] = '{1'b0, 32'(4 * (DEPTH - 1)), 32'h0, 4'h0, 0, 32'h0, 1'b0};
    vecs[14] = '{1'b0, 32'hFFFFFFFC, 32'h0, 4'h0, 0, 32'h0, 1'b1};

    for (int i = 0; i < 15; i++) begin
      model(0, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, erd, eer);
      txn(0, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, vecs[i].hold, rd, er);
      chk($sformatf("vec%0d rdata", i), 64'(rd), 64'(vecs[i].exp_rdata));
      chk($sformatf("vec%0d err", i), 64'(er), 64'(vecs[i].exp_err));
    end

    // Reset during WAITST abandons the store
    @(negedge clk);
    req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'hAAAA5555; req_be = 4'hF;
    req_valid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset in WAITST outputs", outs(0), {29'd0, 1'b1, 1'b0, 1'b0, 32'h0});
    txn(0, 1'b0, 32'h30, 32'h0, 4'h0, 0, rd, er);
    chk("store abandoned by reset", 64'(rd), 64'h0);

    // Reset during RESP keeps the committed store
    @(negedge clk);
    req_we = 1'b1; req_addr = 32'h34; req_wdata = 32'h5A5A1234; req_be = 4'hF;
    req_valid[0] = 1'b1;
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      req_valid[0] = 1'b0;
    end while (!rsp_valid_w[0] && lat < 50);
    chk("RESP reached before reset", 64'(rsp_valid_w[0]), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset in RESP outputs", outs(0), {29'd0, 1'b1, 1'b0, 1'b0, 32'h0});
    model(0, 1'b1, 32'h34, 32'h5A5A1234, 4'hF, erd, eer);
    txn(0, 1'b0, 32'h34, 32'h0, 4'h0, 0, rd, er);
    chk("store kept after RESP reset", 64'(rd), 64'h5A5A1234);

    // WAIT=0 instance: 1-cycle latency and read-after-write
    model(1, 1'b1, 32'h30, 32'h0BADC0DE, 4'hF, erd, eer);
    txn(1, 1'b1, 32'h30, 32'h0BADC0DE, 4'hF, 0, rd, er);
    model(1, 1'b0, 32'h30, 32'h0, 4'h0, erd, eer);
    txn(1, 1'b0, 32'h30, 32'h0, 4'h0, 0, rd, er);
    chk("wait0 RAW", 64'(rd), 64'h0BADC0DE);

    // Randomized traffic against the reference model
    for (int s = 0; s < 2; s++) begin
      for (int n = 0; n < 60; n++) begin
        logic [31:0] a, wd;
        logic        we;
        logic [3:0]  be;
        int          r, hold;
        a  = 32'($urandom_range(0, 15) * 4);
        r  = $urandom_range(0, 9);
        if (r == 0) a = a | 32'($urandom_range(1, 3));
        if (r == 1) a = 32'(4 * DEPTH + 4 * $urandom_range(0, 1000));
        if (r == 2) a = 32'(4 * (DEPTH - 1));
        we   = 1'($urandom);
        wd   = $urandom;
        be   = 4'($urandom_range(0, 15));
        hold = $urandom_range(0, 2);
        model(s, we, a, wd, be, erd, eer);
        txn(s, we, a, wd, be, hold, rd, er);
        chk($sformatf("rand s%0d n%0d rdata", s, n), 64'(rd), 64'(erd));
        chk($sformatf("rand s%0d n%0d err", s, n), 64'(er), 64'(eer));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Word-addressed data-memory responder for the RISC-V core's load/store path.
- Accepts one request at a time over a valid/ready request channel and performs byte-strobed writes or full-word reads.
- Returns a response over a valid/ready response channel after a fixed, programmable number of wait states.
- Replaces the zero-latency data memory when the core or bus needs a stalling memory model.

Parameters:
- DEPTH, 256, number of 32-bit words; legal word index 0..DEPTH-1.
- WAIT, 2, wait-state cycles between request acceptance and response; 0 is legal.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  initiator presents a request.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data.
- req_be  input  4  byte enables; bit i covers wdata[8i+7:8i].
- rsp_valid  output  1  response available.
- rsp_ready  input  1  initiator accepts the response.
- rsp_rdata  output  32  load data; 0 for stores and errors.
- rsp_err  output  1  access fault (misaligned or out of range).

Behaviour:
- FSM states: IDLE, WAITST, RESP.
- Reset, applied on any clk edge with rst=1:
  - State goes to IDLE; wait counter cleared; captured request cleared.
  - req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - Memory array contents are not affected by rst.
- IDLE:
  - req_ready=1.
  - On req_valid=1, capture we/addr/wdata/be in the same edge.
  - If WAIT=0, go to RESP; otherwise load counter with WAIT-1 and go to WAITST.
- WAITST:
  - req_ready=0.
  - Counter decrements each cycle; when it reaches 0, go to RESP.
- Access commit on the edge entering RESP:
  - Error if addr[1:0]!=0 or addr[31:2]>=DEPTH. On error, no memory write occurs; rsp_err=1 and rsp_rdata=0.
  - Legal store: write only the bytes whose be bit is 1. be=0000 is a legal no-op store. rsp_rdata=0.
  - Legal load: rsp_rdata = mem[addr[31:2]], registered. be is ignored for loads.
- RESP:
  - rsp_valid=1 and req_ready=0.
  - rsp_rdata and rsp_err hold stable until the handshake.
  - On rsp_ready=1, go to IDLE next cycle; rsp_valid, rsp_rdata and rsp_err return to 0.
  - No request is accepted in the same cycle as the response handshake.
- Latency: request accepted at edge N gives rsp_valid=1 from cycle N+1+WAIT. Minimum throughput is one transaction per WAIT+2 cycles.
- Read-after-write: a load after a completed store returns the updated data.
- Input stability: req_* inputs are don't-care outside IDLE. Changes to them while busy have no effect.
- rsp_ready=1 while rsp_valid=0 is ignored.
- Reset mid-transaction:
  - In WAITST: the transaction is abandoned and no write is performed.
  - In RESP: the write has already been committed; only the response is dropped.
- Address wrap: none. Out-of-range addresses fault; they do not alias.

Test Plan:
- Reset, then idle: req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0 for 5 cycles.
- WAIT=2, store addr 0x10, wdata 0xDEADBEEF, be=1111, rsp_ready=1 → rsp_valid high exactly 3 cycles after acceptance, rsp_err=0. Then load 0x10 → rsp_rdata=0xDEADBEEF.
- Byte strobes: store 0x11223344 to 0x20 with be=1111, then store 0xAABBCCDD with be=0101 → load 0x20 returns 0x11BB33DD.
- Backpressure: load with rsp_ready=0 for 4 cycles → rsp_valid and rsp_rdata held stable, req_ready=0; a new req_valid is ignored until one cycle after rsp_ready=1.
- Faults:
  - Load 0x22 (misaligned) → rsp_err=1, rsp_rdata=0.
  - Store to byte address 4*DEPTH → rsp_err=1; the word at index 0 is unchanged.
- Reset during WAITST of a store to 0x30 (prior contents 0x0) → after reset, load 0x30 returns 0x0. Repeat with WAIT=0 and confirm 1-cycle latency.
